// File: rtl/eth_pkg.sv
// Shared Ethernet types for the transmit address path: the address pair layout,
// the rewrite modes and well-known MAC constants.
package eth_pkg;

  localparam int unsigned MAC_W = 48;

  localparam logic [MAC_W-1:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  // dst occupies the upper half of the packed pair.
  typedef struct packed {
    logic [MAC_W-1:0] dst;
    logic [MAC_W-1:0] src;
  } address_t;

  typedef enum logic [1:0] {
    ModePass     = 2'd0,
    ModeSwap     = 2'd1,
    ModeLocalSrc = 2'd2,
    ModeRsvd     = 2'd3
  } addr_mode_e;

endpackage

// File: rtl/tx_address_queue_if.sv
// Write/read handshake bundle between the rx capture side, the address queue and the tx framer.
interface tx_address_queue_if
  import eth_pkg::*;
#(
  parameter int unsigned CNT_W = 3
);

  logic [1:0]       mode;
  logic [MAC_W-1:0] local_mac;
  logic             wr_valid;
  logic             wr_ready;
  address_t         rx_address;
  logic             rd_valid;
  logic             rd_ready;
  address_t         tx_address;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clr_overflow;

  modport master (
    output mode, local_mac, wr_valid, rx_address, rd_ready, clr_overflow,
    input  wr_ready, rd_valid, tx_address, count, overflow
  );

  modport slave (
    input  mode, local_mac, wr_valid, rx_address, rd_ready, clr_overflow,
    output wr_ready, rd_valid, tx_address, count, overflow
  );

endinterface

// File: rtl/tx_address_xform.sv
// Combinational address-pair rewrite applied to an incoming pair before it is stored.
module tx_address_xform
  import eth_pkg::*;
(
  input  logic [1:0]       mode,
  input  logic [MAC_W-1:0] local_mac,
  input  address_t         rx_address,
  output address_t         stored
);

  always_comb begin
    stored = rx_address;
    unique case (addr_mode_e'(mode))
      ModeSwap: begin
        stored.dst = rx_address.src;
        stored.src = rx_address.dst;
      end
      ModeLocalSrc: begin
        stored.dst = rx_address.src;
        stored.src = local_mac;
      end
      default: stored = rx_address;
    endcase
  end

endmodule

// File: rtl/tx_address_queue.sv
// First-word fall-through FIFO of rewritten MAC address pairs feeding the transmit framer,
// with a sticky overflow flag for writes offered while full.
module tx_address_queue
  import eth_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input logic                clk,
  input logic                rst,
  tx_address_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  address_t         mem_q [DEPTH];
  address_t         wr_data;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, wr_en, rd_en;

  tx_address_xform u_xform (
    .mode       (bus.mode),
    .local_mac  (bus.local_mac),
    .rx_address (bus.rx_address),
    .stored     (wr_data)
  );

  // Full is judged on the registered count, so a pop never frees a slot in the same cycle.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = bus.wr_valid && !full;
  assign rd_en = bus.rd_ready && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Set takes priority over clear.
    if (bus.wr_valid && full) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign bus.wr_ready   = !full;
  assign bus.rd_valid   = !empty;
  assign bus.tx_address = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_tx_address_queue.sv
// Self-checking bench for tx_address_queue: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_tx_address_queue;
  import eth_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_address_queue_if #(.CNT_W(CNT_W)) bus ();

  tx_address_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int       n_checks = 0;
  int       n_fail   = 0;
  address_t model_q[$];
  bit       model_ovf;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic address_t rewrite(input logic [1:0] m, input logic [MAC_W-1:0] lm,
                                       input address_t rx);
    address_t r;
    case (m)
      2'd1:    r = '{dst: rx.src, src: rx.dst};
      2'd2:    r = '{dst: rx.src, src: lm};
      default: r = rx;
    endcase
    return r;
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic cycle();
    int sz;
    address_t head;
    @(posedge clk);
    sz = model_q.size();
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (bus.wr_valid && sz == DEPTH) model_ovf = 1'b1;
      else if (bus.clr_overflow)      model_ovf = 1'b0;
      if (bus.rd_ready && sz != 0) void'(model_q.pop_front());
      if (bus.wr_valid && sz != DEPTH)
        model_q.push_back(rewrite(bus.mode, bus.local_mac, bus.rx_address));
    end
    #1;
    sz   = model_q.size();
    head = (sz != 0) ? model_q[0] : '0;
    check_eq("count", 128'(bus.count), 128'(sz));
    check_eq("rd_valid", 128'(bus.rd_valid), 128'(sz != 0));
    check_eq("wr_ready", 128'(bus.wr_ready), 128'(sz != DEPTH));
    check_eq("tx_address", 128'(bus.tx_address), 128'(head));
    check_eq("overflow", 128'(bus.overflow), 128'(model_ovf));
  endtask

  task automatic idle_inputs();
    rst              = 1'b0;
    bus.wr_valid     = 1'b0;
    bus.rd_ready     = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.mode         = 2'd0;
    bus.local_mac    = '0;
    bus.rx_address   = '0;
  endtask

  initial begin
    address_t rx;
    idle_inputs();
    model_ovf = 1'b0;

    // Reset with a write offered: nothing may be stored.
    rst = 1'b1;
    bus.wr_valid = 1'b1;
    bus.rx_address = {48'hDEAD_BEEF_0001, 48'hDEAD_BEEF_0002};
    cycle();
    cycle();
    check_eq("rst_count", 128'(bus.count), 128'd0);
    check_eq("rst_tx", 128'(bus.tx_address), 128'd0);
    idle_inputs();
    cycle();

    // SWAP rewrite.
    bus.mode = 2'd1;
    bus.rx_address = '{dst: 48'h1111_1111_1111, src: 48'h2222_2222_2222};
    bus.wr_valid = 1'b1;
    cycle();
    idle_inputs();
    check_eq("swap_tx", 128'(bus.tx_address), 128'({48'h2222_2222_2222, 48'h1111_1111_1111}));
    check_eq("swap_valid", 128'(bus.rd_valid), 128'd1);
    bus.rd_ready = 1'b1;
    cycle();
    idle_inputs();

    // LOCAL_SRC rewrite; later mode/local_mac changes must not touch the queued entry.
    bus.mode = 2'd2;
    bus.local_mac = 48'h02AA_BBCC_DDEE;
    bus.rx_address = '{dst: 48'h4444_4444_4444, src: 48'h3333_3333_3333};
    bus.wr_valid = 1'b1;
    cycle();
    idle_inputs();
    bus.mode = 2'd1;
    bus.local_mac = 48'h0123_4567_89AB;
    cycle();
    check_eq("local_tx", 128'(bus.tx_address), 128'({48'h3333_3333_3333, 48'h02AA_BBCC_DDEE}));
    bus.rd_ready = 1'b1;
    cycle();
    idle_inputs();

    // Fill past full: 4 accepted, overflow set.
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1;
      bus.mode = 2'(i);
      bus.local_mac = 48'(i) + 48'hA0;
      bus.rx_address = '{dst: 48'(i) + 48'h100, src: 48'(i) + 48'h200};
      cycle();
    end
    check_eq("fill_count", 128'(bus.count), 128'(DEPTH));
    check_eq("fill_ovf", 128'(bus.overflow), 128'd1);
    // Clear and set in the same cycle: set wins.
    bus.clr_overflow = 1'b1;
    cycle();
    check_eq("ovf_set_wins", 128'(bus.overflow), 128'd1);
    bus.clr_overflow = 1'b0;

    // Full with simultaneous pop and write: pop only, then both.
    bus.rd_ready = 1'b1;
    bus.rx_address = '{dst: 48'h5555_0000_0001, src: 48'h6666_0000_0001};
    cycle();
    check_eq("full_pop_count", 128'(bus.count), 128'd3);
    bus.rx_address = '{dst: 48'h5555_0000_0002, src: 48'h6666_0000_0002};
    cycle();
    check_eq("rw_count", 128'(bus.count), 128'd3);
    // Keep streaming to wrap the pointers several times.
    for (int i = 0; i < 12; i++) begin
      bus.rx_address = '{dst: 48'(i) + 48'h7000, src: 48'(i) + 48'h8000};
      cycle();
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("drain_empty", 128'(bus.rd_valid), 128'd0);
    idle_inputs();
    bus.clr_overflow = 1'b1;
    cycle();
    check_eq("ovf_clr", 128'(bus.overflow), 128'd0);
    idle_inputs();

    // Reset mid-stream with a concurrent write.
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.rx_address = '{dst: 48'(i) + 48'h9000, src: 48'(i) + 48'hA000};
      cycle();
    end
    rst = 1'b1;
    cycle();
    check_eq("midrst_count", 128'(bus.count), 128'd0);
    check_eq("midrst_valid", 128'(bus.rd_valid), 128'd0);
    idle_inputs();
    cycle();
    check_eq("midrst_nostore", 128'(bus.count), 128'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.wr_valid     = ($urandom_range(0, 99) < 55);
      bus.rd_ready     = ($urandom_range(0, 99) < 45);
      bus.clr_overflow = ($urandom_range(0, 29) == 0);
      bus.mode         = 2'($urandom_range(0, 3));
      bus.local_mac    = {16'($urandom), $urandom};
      rx               = {$urandom, $urandom, $urandom};
      bus.rx_address   = rx;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
